sbox_req_scheduler: RTL and testbench

Shares one pipelined masked AES S-box (aes_sbox, PIPELINED=1, EIGHT_STAGED=0) between NREQ requesters, such as the SubBytes datapath and the key schedule. Each cycle it picks at most one requester with a round-robin arbiter and drives that requester's shared byte into the S-box. It tracks the in-flight tokens in a tag shift register matched to the S-box latency, and routes each result back to its owner. It also gates the fresh-randomness source: it never lets masked data sit in the S-box pipeline without fresh randomness, and it flushes the pipeline if randomness drops.

---
 rtl/sbox_sched_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/sbox_req_scheduler.sv | 117 +++++++++++
 tb/tb_sbox_req_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_sched_pkg.sv
// Shared constants and helpers for the S-box request scheduler and the round controller.
package sbox_sched_pkg;

  // Cycles from S-box input valid to S-box output valid (5-stage pipelined configuration).
  localparam int SBOX_LATENCY_DEFAULT = 5;

  // Width of a requester id; at least one bit even for a single requester.
  function automatic int tag_width(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last-granted index, wrapping.
module rr_arbiter
  import sbox_sched_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW  = tag_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  // Scan from ptr+1 cyclically; the first asserted request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  // Pointer remembers the last winner; reset so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IW'(NREQ - 1);
    end else if (update && found) begin
      ptr <= idx;
    end
  end

endmodule

// File: rtl/sbox_req_scheduler.sv
// Shares one pipelined masked S-box between NREQ requesters, tracks in-flight
// tokens with a tag pipe and gates the fresh-randomness source.
//
// Handshake: a request transfers in the cycle where ReqValidxSI[r] and
// ReqReadyxSO[r] are both high; ReqReadyxSO is combinational and at most one
// bit is set. Responses are a one-cycle RspValidxSO pulse with no backpressure.
module sbox_req_scheduler
  import sbox_sched_pkg::*;
#(
  parameter int SHARES       = 2,
  parameter int NREQ         = 2,
  parameter int SBOX_LATENCY = SBOX_LATENCY_DEFAULT
) (
  input  logic                     ClkxCI,
  input  logic                     RstxBI,
  input  logic [NREQ-1:0]          ReqValidxSI,
  output logic [NREQ-1:0]          ReqReadyxSO,
  input  logic [NREQ*8*SHARES-1:0] ReqDataxDI,
  output logic [8*SHARES-1:0]      SboxInxDO,
  input  logic [8*SHARES-1:0]      SboxOutxDI,
  input  logic                     RndValidxSI,
  output logic                     RndEnxSO,
  output logic [NREQ-1:0]          RspValidxSO,
  output logic [8*SHARES-1:0]      RspDataxDO,
  input  logic                     FlushxSI,
  output logic                     BusyxSO,
  output logic                     ErrorxSO,
  input  logic                     ErrClrxSI
);

  localparam int IW = tag_width(NREQ);

  logic [NREQ-1:0]         req_masked;
  logic [NREQ-1:0]         gnt;
  logic [IW-1:0]           gnt_idx;
  logic                    allow;
  logic                    grant;
  logic                    any_tag;
  logic                    rnd_loss;
  logic                    err_q;
  logic [SBOX_LATENCY-1:0] tag_v;
  logic [IW-1:0]           tag_id [SBOX_LATENCY];

  // Grants need fresh masks, no pending error, no flush, and reset released.
  assign allow      = RstxBI & RndValidxSI & ~err_q & ~FlushxSI;
  assign req_masked = ReqValidxSI & {NREQ{allow}};
  assign grant      = |req_masked;
  assign any_tag    = |tag_v;
  assign rnd_loss   = any_tag & ~RndValidxSI;

  assign ReqReadyxSO = gnt;
  assign RndEnxSO    = grant | any_tag;
  assign BusyxSO     = any_tag;
  assign ErrorxSO    = err_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (ClkxCI),
    .rst_n  (RstxBI),
    .req    (req_masked),
    .update (grant),
    .gnt    (gnt),
    .idx    (gnt_idx)
  );

  // One-hot AND-OR mux, share by share; shares are never combined.
  always_comb begin
    SboxInxDO = '0;
    for (int s = 0; s < SHARES; s++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (gnt[r]) begin
          SboxInxDO[s*8 +: 8] = SboxInxDO[s*8 +: 8] | ReqDataxDI[(r*SHARES + s)*8 +: 8];
        end
      end
    end
  end

  // Tag pipe mirrors the S-box pipeline; it never stalls, only clears on flush or mask loss.
  always_ff @(posedge ClkxCI) begin
    if (!RstxBI) begin
      tag_v <= '0;
      for (int i = 0; i < SBOX_LATENCY; i++) tag_id[i] <= '0;
    end else if (FlushxSI || rnd_loss) begin
      tag_v <= '0;
    end else begin
      tag_v[0]  <= grant;
      tag_id[0] <= gnt_idx;
      for (int i = 1; i < SBOX_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Sticky error on mask loss with tokens in flight; setting has priority over clearing.
  always_ff @(posedge ClkxCI) begin
    if (!RstxBI) begin
      err_q <= 1'b0;
    end else if (rnd_loss) begin
      err_q <= 1'b1;
    end else if (ErrClrxSI) begin
      err_q <= 1'b0;
    end
  end

  // Route the last-stage token's result to its owner; outputs are zero otherwise.
  always_comb begin
    RspValidxSO = '0;
    RspDataxDO  = '0;
    if (tag_v[SBOX_LATENCY-1]) begin
      RspDataxDO = SboxOutxDI;
      for (int r = 0; r < NREQ; r++) begin
        if (tag_id[SBOX_LATENCY-1] == IW'(r)) RspValidxSO[r] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sbox_req_scheduler.sv
// Directed bench for sbox_req_scheduler (SHARES=2, NREQ=2, SBOX_LATENCY=5).
// The S-box is modelled as a 5-cycle delay line followed by XOR with 0x3C3C.
module tb_sbox_req_scheduler;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [31:0]  req_data;
  logic [W-1:0] sbox_in;
  logic [W-1:0] sbox_out;
  logic         rnd_valid;
  logic         rnd_en;
  logic [1:0]   rsp_valid;
  logic [W-1:0] rsp_data;
  logic         flush;
  logic         busy;
  logic         err;
  logic         err_clr;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] dl [5];
  logic [W-1:0] d0, d1, exp_in, exp_rsp;

  typedef struct {
    logic [1:0] req;
    logic [1:0] ready;
    logic [1:0] rsp;
  } vec_t;

  vec_t tbl [30];

  sbox_req_scheduler #(.SHARES(2), .NREQ(2), .SBOX_LATENCY(5)) dut (
    .ClkxCI      (clk),
    .RstxBI      (rst_n),
    .ReqValidxSI (req_valid),
    .ReqReadyxSO (req_ready),
    .ReqDataxDI  (req_data),
    .SboxInxDO   (sbox_in),
    .SboxOutxDI  (sbox_out),
    .RndValidxSI (rnd_valid),
    .RndEnxSO    (rnd_en),
    .RspValidxSO (rsp_valid),
    .RspDataxDO  (rsp_data),
    .FlushxSI    (flush),
    .BusyxSO     (busy),
    .ErrorxSO    (err),
    .ErrClrxSI   (err_clr)
  );

  // clock / S-box model
  always #5 clk = ~clk;

  initial for (int i = 0; i < 5; i++) dl[i] = '0;

  always @(posedge clk) begin
    dl[0] <= sbox_in;
    for (int i = 1; i < 5; i++) dl[i] <= dl[i-1];
  end

  assign sbox_out = dl[4] ^ 16'h3C3C;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] rq, input logic rv, input logic fl, input logic clr);
    req_valid = rq;
    rnd_valid = rv;
    flush     = fl;
    err_clr   = clr;
    req_data  = {d1, d0};
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_busy_at(input int r);
    logic b;
    b = 1'b0;
    for (int g = r - 5; g < r; g++) begin
      if (g >= 0 && tbl[g].ready != 2'b00) b = 1'b1;
    end
    return b;
  endfunction

  initial begin
    // table: single request at row 10, a req1 grant to align the pointer, then contention
    for (int r = 0; r < 30; r++) tbl[r] = '{2'b00, 2'b00, 2'b00};
    tbl[10] = '{2'b01, 2'b01, 2'b00};
    tbl[11] = '{2'b10, 2'b10, 2'b00};
    tbl[15] = '{2'b00, 2'b00, 2'b01};
    tbl[16] = '{2'b11, 2'b01, 2'b10};
    tbl[17] = '{2'b11, 2'b10, 2'b00};
    tbl[18] = '{2'b11, 2'b01, 2'b00};
    tbl[19] = '{2'b11, 2'b10, 2'b00};
    tbl[20] = '{2'b11, 2'b01, 2'b00};
    tbl[21] = '{2'b11, 2'b10, 2'b01};
    tbl[22] = '{2'b11, 2'b01, 2'b10};
    tbl[23] = '{2'b11, 2'b10, 2'b01};
    tbl[24] = '{2'b00, 2'b00, 2'b10};
    tbl[25] = '{2'b00, 2'b00, 2'b01};
    tbl[26] = '{2'b00, 2'b00, 2'b10};
    tbl[27] = '{2'b00, 2'b00, 2'b01};
    tbl[28] = '{2'b00, 2'b00, 2'b10};

    // reset with requests pending: nothing may be accepted
    rst_n = 1'b0;
    d0 = 16'h1111;
    d1 = 16'h2222;
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_sbox_in", 32'(sbox_in), 32'h0);
    chk("rst_rnd_en", 32'(rnd_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    tick();
    rst_n = 1'b1;

    // table-driven run: idle, single request, contention
    for (int r = 0; r < 30; r++) begin
      d0 = 16'hA55A ^ {8'(r - 10), 8'(r - 10)};
      d1 = 16'h1234 ^ {8'(r), 8'(3 * r)};
      drive(tbl[r].req, 1'b1, 1'b0, 1'b0);
      #2;
      exp_in = (tbl[r].ready == 2'b01) ? d0 : (tbl[r].ready == 2'b10) ? d1 : 16'h0;
      if (tbl[r].ready != 2'b00) exp_q.push_back(exp_in ^ 16'h3C3C);
      chk($sformatf("row%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
      chk($sformatf("row%0d_sbox_in", r), 32'(sbox_in), 32'(exp_in));
      chk($sformatf("row%0d_rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].rsp));
      if (tbl[r].rsp != 2'b00) begin
        exp_rsp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        chk($sformatf("row%0d_rsp_data", r), 32'(rsp_data), 32'(exp_rsp));
      end else begin
        chk($sformatf("row%0d_rsp_data_idle", r), 32'(rsp_data), 32'h0);
      end
      chk($sformatf("row%0d_busy", r), 32'(busy), 32'(exp_busy_at(r)));
      chk($sformatf("row%0d_rnd_en", r), 32'(rnd_en),
          32'(exp_busy_at(r) | (tbl[r].ready != 2'b00)));
      chk($sformatf("row%0d_err", r), 32'(err), 32'h0);
      tick();
    end

    // randomness loss with 3 tokens in flight
    d0 = 16'h1357;
    d1 = 16'h2468;
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1'b1, 1'b0, 1'b0);
      #2;
      chk("loss_fill_ready", 32'(req_ready), 32'h1);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    chk("loss_rnd_en", 32'(rnd_en), 32'h1);
    chk("loss_ready", 32'(req_ready), 32'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 1'b1, 1'b0, 1'b0);
      #2;
      chk("loss_err", 32'(err), 32'h1);
      chk("loss_blocked", 32'(req_ready), 32'h0);
      chk("loss_no_rsp", 32'(rsp_valid), 32'h0);
      chk("loss_busy", 32'(busy), 32'h0);
      chk("loss_rnd_en_off", 32'(rnd_en), 32'h0);
      tick();
    end
    drive(2'b00, 1'b1, 1'b0, 1'b1);
    #2;
    chk("clr_err_still", 32'(err), 32'h1);
    tick();
    drive(2'b01, 1'b1, 1'b0, 1'b0);
    #2;
    chk("clr_err_gone", 32'(err), 32'h0);
    chk("clr_regrant", 32'(req_ready), 32'h1);
    chk("clr_sbox_in", 32'(sbox_in), 32'h1357);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 1'b1, 1'b0, 1'b0);
      #2;
      chk("clr_wait_rsp", 32'(rsp_valid), 32'h0);
      tick();
    end
    #2;
    chk("clr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("clr_rsp_data", 32'(rsp_data), 32'(16'h1357 ^ 16'h3C3C));
    tick();

    // flush with 4 tokens: only the last-stage token responds
    d0 = 16'hC0DE;
    d1 = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0, 1'b0);
      #2;
      chk("fl_ready", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
      tick();
    end
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    drive(2'b11, 1'b1, 1'b1, 1'b0);
    #2;
    chk("fl_no_grant", 32'(req_ready), 32'h0);
    chk("fl_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("fl_rsp_data", 32'(rsp_data), 32'(16'hBEEF ^ 16'h3C3C));
    chk("fl_sbox_in", 32'(sbox_in), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 1'b1, 1'b0, 1'b0);
      #2;
      chk("fl_dropped", 32'(rsp_valid), 32'h0);
      chk("fl_busy", 32'(busy), 32'h0);
      chk("fl_err", 32'(err), 32'h0);
      tick();
    end

    // reset mid-operation with 4 tokens in flight
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0, 1'b0);
      #2;
      chk("mr_ready", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
      tick();
    end
    rst_n = 1'b0;
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    #2;
    chk("mr_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    #2;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mr_rsp_data", 32'(rsp_data), 32'h0);
    chk("mr_rnd_en", 32'(rnd_en), 32'h0);
    chk("mr_sbox_in", 32'(sbox_in), 32'h0);
    chk("mr_err", 32'(err), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 1'b1, 1'b0, 1'b0);
      #2;
      chk("mr_no_stale", 32'(rsp_valid), 32'h0);
      tick();
    end
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    #2;
    chk("mr_first_grant", 32'(req_ready), 32'h1);
    tick();
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    tick();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
